// File: rtl/tsc_pkg.sv
// Shared encodings for the TSC multi-cycle controller: FSM states, ISA opcodes/funcs,
// ALU codes, datapath mux selects and the instruction class produced by the decoder.
package tsc_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_BR   = 3'd5,
    ST_HALT = 3'd6
  } state_e;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_NOT = 4'd4;
  localparam logic [3:0] ALU_TCP = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_LHI = 4'd8;

  localparam logic [1:0] PC_SRC_NEXT   = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] ALU_A_PC      = 2'd0;
  localparam logic [1:0] ALU_A_RS      = 2'd1;
  localparam logic [1:0] ALU_A_NEXT_PC = 2'd2;

  localparam logic [1:0] ALU_B_RT  = 2'd0;
  localparam logic [1:0] ALU_B_IMM = 2'd1;
  localparam logic [1:0] ALU_B_ONE = 2'd2;

  typedef enum logic [3:0] {
    CL_RALU   = 4'd0,
    CL_ADI    = 4'd1,
    CL_ORI    = 4'd2,
    CL_LHI    = 4'd3,
    CL_LWD    = 4'd4,
    CL_SWD    = 4'd5,
    CL_BRANCH = 4'd6,
    CL_JMP    = 4'd7,
    CL_JAL    = 4'd8,
    CL_JPR    = 4'd9,
    CL_JRL    = 4'd10,
    CL_WWD    = 4'd11,
    CL_HLT    = 4'd12,
    CL_NOP    = 4'd13
  } inst_class_e;

  function automatic logic is_r_alu(input logic [5:0] f);
    return (f <= FN_SHR);
  endfunction

endpackage

// File: rtl/tsc_inst_decoder.sv
// Combinational opcode/func to instruction-class mapping; anything not in the ISA
// decodes as a NOP so the controller always retires it cleanly.
module tsc_inst_decoder
  import tsc_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic [5:0] i_func,
  output logic [3:0] o_class
);

  inst_class_e w_class;

  always_comb begin
    w_class = CL_NOP;
    case (i_opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: w_class = CL_BRANCH;
      OP_ADI:   w_class = CL_ADI;
      OP_ORI:   w_class = CL_ORI;
      OP_LHI:   w_class = CL_LHI;
      OP_LWD:   w_class = CL_LWD;
      OP_SWD:   w_class = CL_SWD;
      OP_JMP:   w_class = CL_JMP;
      OP_JAL:   w_class = CL_JAL;
      OP_RTYPE: begin
        if (is_r_alu(i_func)) begin
          w_class = CL_RALU;
        end else begin
          case (i_func)
            FN_JPR:  w_class = CL_JPR;
            FN_JRL:  w_class = CL_JRL;
            FN_WWD:  w_class = CL_WWD;
            FN_HLT:  w_class = CL_HLT;
            default: w_class = CL_NOP;
          endcase
        end
      end
      default:  w_class = CL_NOP;
    endcase
  end

  assign o_class = w_class;

endmodule

// File: rtl/tsc_multicycle_controller.sv
// Moore control FSM for the 16-bit multi-cycle TSC datapath (IF/ID/BR/EX/MEM/WB/HALT),
// plus the retired-instruction counter and halt flag.
module tsc_multicycle_controller
  import tsc_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int IF_LAT_MAX = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [3:0]           i_opcode,
  input  logic [5:0]           i_func,
  input  logic                 i_bcond,
  input  logic                 i_mem_ready,
  output logic                 o_inst_fetch,
  output logic                 o_ir_write,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_reg_write,
  output logic                 o_reg_dst,
  output logic                 o_pc_to_reg,
  output logic                 o_mem_to_reg,
  output logic [1:0]           o_alu_a_sel,
  output logic [1:0]           o_alu_b_sel,
  output logic [3:0]           o_alu_func,
  output logic [1:0]           o_branch_type,
  output logic                 o_pc_store,
  output logic                 o_branch_dst_store,
  output logic [1:0]           o_pc_src,
  output logic                 o_pvs_update,
  output logic                 o_wwd_en,
  output logic [WORD_SIZE-1:0] o_num_inst,
  output logic                 o_is_halted
);

  state_e               r_state;
  state_e               w_next_state;
  logic [3:0]           w_class;
  logic                 w_fetch_done;
  logic                 w_enter_halt;
  logic [WORD_SIZE-1:0] r_num_inst;
  logic                 r_is_halted;

  tsc_inst_decoder u_decoder (
    .i_opcode (i_opcode),
    .i_func   (i_func),
    .o_class  (w_class)
  );

  // Fetch stalls come only from mem_ready; a nonzero IF_LAT_MAX is unsupported and never completes a fetch.
  assign w_fetch_done = (IF_LAT_MAX == 0) ? i_mem_ready : 1'b0;
  assign w_enter_halt = (r_state == ST_ID) && (w_next_state == ST_HALT);

  always_comb begin
    w_next_state       = r_state;
    o_inst_fetch       = 1'b0;
    o_ir_write         = 1'b0;
    o_mem_read         = 1'b0;
    o_mem_write        = 1'b0;
    o_reg_write        = 1'b0;
    o_reg_dst          = 1'b0;
    o_pc_to_reg        = 1'b0;
    o_mem_to_reg       = 1'b0;
    o_alu_a_sel        = ALU_A_PC;
    o_alu_b_sel        = ALU_B_RT;
    o_alu_func         = ALU_ADD;
    o_branch_type      = 2'd0;
    o_pc_store         = 1'b0;
    o_branch_dst_store = 1'b0;
    o_pc_src           = PC_SRC_NEXT;
    o_pvs_update       = 1'b0;
    o_wwd_en           = 1'b0;
    case (r_state)
      ST_IF: begin
        o_inst_fetch = 1'b1;
        if (w_fetch_done) begin
          o_ir_write   = 1'b1;
          w_next_state = ST_ID;
        end else begin
          w_next_state = ST_IF;
        end
      end
      ST_ID: begin
        o_alu_a_sel = ALU_A_PC;
        o_alu_b_sel = ALU_B_ONE;
        o_alu_func  = ALU_ADD;
        o_pc_store  = 1'b1;
        if (w_class == CL_HLT) begin
          w_next_state = ST_HALT;
        end else if (w_class == CL_BRANCH) begin
          w_next_state = ST_BR;
        end else begin
          w_next_state = ST_EX;
        end
      end
      ST_BR: begin
        o_alu_a_sel        = ALU_A_NEXT_PC;
        o_alu_b_sel        = ALU_B_IMM;
        o_alu_func         = ALU_ADD;
        o_branch_dst_store = 1'b1;
        w_next_state       = ST_EX;
      end
      ST_EX: begin
        case (w_class)
          CL_RALU: begin
            o_alu_a_sel  = ALU_A_RS;
            o_alu_b_sel  = ALU_B_RT;
            o_alu_func   = i_func[3:0];
            w_next_state = ST_WB;
          end
          CL_ADI, CL_ORI, CL_LHI: begin
            o_alu_a_sel  = ALU_A_RS;
            o_alu_b_sel  = ALU_B_IMM;
            o_alu_func   = (w_class == CL_ADI) ? ALU_ADD :
                           (w_class == CL_ORI) ? ALU_ORR : ALU_LHI;
            w_next_state = ST_WB;
          end
          CL_LWD, CL_SWD: begin
            o_alu_a_sel  = ALU_A_RS;
            o_alu_b_sel  = ALU_B_IMM;
            o_alu_func   = ALU_ADD;
            w_next_state = ST_MEM;
          end
          CL_BRANCH: begin
            o_alu_a_sel   = ALU_A_RS;
            o_alu_b_sel   = ALU_B_RT;
            o_branch_type = i_opcode[1:0];
            o_pc_src      = i_bcond ? PC_SRC_BRANCH : PC_SRC_NEXT;
            o_pvs_update  = 1'b1;
            w_next_state  = ST_IF;
          end
          CL_JMP, CL_JAL: begin
            o_reg_write  = (w_class == CL_JAL);
            o_pc_to_reg  = (w_class == CL_JAL);
            o_pc_src     = PC_SRC_JUMP;
            o_pvs_update = 1'b1;
            w_next_state = ST_IF;
          end
          CL_JPR, CL_JRL: begin
            o_reg_write  = (w_class == CL_JRL);
            o_pc_to_reg  = (w_class == CL_JRL);
            o_pc_src     = PC_SRC_RS;
            o_pvs_update = 1'b1;
            w_next_state = ST_IF;
          end
          CL_WWD: begin
            o_wwd_en     = 1'b1;
            o_pc_src     = PC_SRC_NEXT;
            o_pvs_update = 1'b1;
            w_next_state = ST_IF;
          end
          default: begin
            o_pc_src     = PC_SRC_NEXT;
            o_pvs_update = 1'b1;
            w_next_state = ST_IF;
          end
        endcase
      end
      ST_MEM: begin
        if (w_class == CL_LWD) begin
          o_mem_read   = 1'b1;
          w_next_state = i_mem_ready ? ST_WB : ST_MEM;
        end else if (w_class == CL_SWD) begin
          o_mem_write  = 1'b1;
          o_pvs_update = i_mem_ready;
          w_next_state = i_mem_ready ? ST_IF : ST_MEM;
        end else begin
          w_next_state = ST_IF;
        end
      end
      ST_WB: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = (w_class == CL_RALU);
        o_mem_to_reg = (w_class == CL_LWD);
        o_pc_src     = PC_SRC_NEXT;
        o_pvs_update = 1'b1;
        w_next_state = ST_IF;
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_IF;
      end
    endcase
  end

  // HLT counts on its way into HALT since it never raises pvs_update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IF;
      r_num_inst  <= {WORD_SIZE{1'b0}};
      r_is_halted <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (o_pvs_update || w_enter_halt) begin
        r_num_inst <= r_num_inst + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end
      if (w_enter_halt) begin
        r_is_halted <= 1'b1;
      end
    end
  end

  assign o_num_inst  = r_num_inst;
  assign o_is_halted = r_is_halted;

endmodule

// File: tb/tb_tsc_multicycle_controller.sv
// Directed bench for tsc_multicycle_controller: a vector table of single instructions
// checked at their retire cycle, plus hand sequences for stalls, halt, reset and wrap.
module tb_tsc_multicycle_controller;

  logic        i_clk;
  logic        i_reset;
  logic [3:0]  i_opcode;
  logic [5:0]  i_func;
  logic        i_bcond;
  logic        i_mem_ready;
  logic        o_inst_fetch, o_ir_write, o_mem_read, o_mem_write;
  logic        o_reg_write, o_reg_dst, o_pc_to_reg, o_mem_to_reg;
  logic [1:0]  o_alu_a_sel, o_alu_b_sel, o_branch_type, o_pc_src;
  logic [3:0]  o_alu_func;
  logic        o_pc_store, o_branch_dst_store, o_pvs_update, o_wwd_en;
  logic [15:0] o_num_inst;
  logic        o_is_halted;

  tsc_multicycle_controller dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_opcode           (i_opcode),
    .i_func             (i_func),
    .i_bcond            (i_bcond),
    .i_mem_ready        (i_mem_ready),
    .o_inst_fetch       (o_inst_fetch),
    .o_ir_write         (o_ir_write),
    .o_mem_read         (o_mem_read),
    .o_mem_write        (o_mem_write),
    .o_reg_write        (o_reg_write),
    .o_reg_dst          (o_reg_dst),
    .o_pc_to_reg        (o_pc_to_reg),
    .o_mem_to_reg       (o_mem_to_reg),
    .o_alu_a_sel        (o_alu_a_sel),
    .o_alu_b_sel        (o_alu_b_sel),
    .o_alu_func         (o_alu_func),
    .o_branch_type      (o_branch_type),
    .o_pc_store         (o_pc_store),
    .o_branch_dst_store (o_branch_dst_store),
    .o_pc_src           (o_pc_src),
    .o_pvs_update       (o_pvs_update),
    .o_wwd_en           (o_wwd_en),
    .o_num_inst         (o_num_inst),
    .o_is_halted        (o_is_halted)
  );

  typedef struct packed {
    logic       inst_fetch;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       pc_to_reg;
    logic       mem_to_reg;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [3:0] alu_func;
    logic [1:0] branch_type;
    logic       pc_store;
    logic       branch_dst_store;
    logic [1:0] pc_src;
    logic       pvs_update;
    logic       wwd_en;
  } ctl_t;

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    logic       bc;
    int         cyc;
    ctl_t       ctl;
  } vec_t;

  int          checks;
  int          errors;
  logic [15:0] exp_cnt;
  ctl_t        log_r [32];
  vec_t        vecs  [17];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic ctl_t sample();
    ctl_t s;
    s = {o_inst_fetch, o_ir_write, o_mem_read, o_mem_write, o_reg_write, o_reg_dst,
         o_pc_to_reg, o_mem_to_reg, o_alu_a_sel, o_alu_b_sel, o_alu_func, o_branch_type,
         o_pc_store, o_branch_dst_store, o_pc_src, o_pvs_update, o_wwd_en};
    return s;
  endfunction

  function automatic ctl_t retire(input logic rw, input logic rd, input logic p2r,
                                  input logic m2r, input logic mw, input logic [1:0] a,
                                  input logic [1:0] b, input logic [1:0] bt,
                                  input logic [1:0] ps, input logic ww);
    ctl_t e;
    e             = '0;
    e.reg_write   = rw;
    e.reg_dst     = rd;
    e.pc_to_reg   = p2r;
    e.mem_to_reg  = m2r;
    e.mem_write   = mw;
    e.alu_a_sel   = a;
    e.alu_b_sel   = b;
    e.branch_type = bt;
    e.pc_src      = ps;
    e.wwd_en      = ww;
    e.pvs_update  = 1'b1;
    return e;
  endfunction

  task automatic chk_ctl(input string nm, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    i_reset     = 1'b1;
    i_mem_ready = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  // Entered just after a rising edge with the FSM in IF; returns the same way after the retire edge.
  task automatic run_instr(input logic [3:0] op, input logic [5:0] fn, input logic bc,
                           input int if_stall, input int mem_stall, output int ncyc);
    int ifs;
    int mems;
    ifs      = if_stall;
    mems     = mem_stall;
    ncyc     = 0;
    i_opcode = op;
    i_func   = fn;
    i_bcond  = bc;
    for (int c = 0; c < 32; c++) begin
      if (o_inst_fetch && ifs > 0) begin
        i_mem_ready = 1'b0;
        ifs--;
      end else if ((o_mem_read || o_mem_write) && mems > 0) begin
        i_mem_ready = 1'b0;
        mems--;
      end else begin
        i_mem_ready = 1'b1;
      end
      @(negedge i_clk);
      log_r[c] = sample();
      ncyc     = c + 1;
      @(posedge i_clk);
      #1;
      if (log_r[c].pvs_update) break;
    end
    i_mem_ready = 1'b1;
  endtask

  initial begin
    int   n;
    int   cnt;
    ctl_t e;
    logic seen;

    checks   = 0;
    errors   = 0;
    i_opcode = 4'd0;
    i_func   = 6'd0;
    i_bcond  = 1'b0;

    vecs[0]  = '{4'd15, 6'd0,  1'b0, 4, retire(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0)};
    vecs[1]  = '{4'd15, 6'd5,  1'b0, 4, retire(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0)};
    vecs[2]  = '{4'd4,  6'd0,  1'b0, 4, retire(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0)};
    vecs[3]  = '{4'd6,  6'd0,  1'b0, 4, retire(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0)};
    vecs[4]  = '{4'd7,  6'd0,  1'b0, 5, retire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0)};
    vecs[5]  = '{4'd8,  6'd0,  1'b0, 4, retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0)};
    vecs[6]  = '{4'd1,  6'd0,  1'b1, 4, retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd1, 2'd1, 1'b0)};
    vecs[7]  = '{4'd1,  6'd0,  1'b0, 4, retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd1, 2'd0, 1'b0)};
    vecs[8]  = '{4'd3,  6'd0,  1'b1, 4, retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd3, 2'd1, 1'b0)};
    vecs[9]  = '{4'd0,  6'd0,  1'b0, 4, retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0)};
    vecs[10] = '{4'd9,  6'd0,  1'b0, 3, retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 1'b0)};
    vecs[11] = '{4'd10, 6'd0,  1'b0, 3, retire(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 1'b0)};
    vecs[12] = '{4'd15, 6'd25, 1'b0, 3, retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3, 1'b0)};
    vecs[13] = '{4'd15, 6'd26, 1'b0, 3, retire(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3, 1'b0)};
    vecs[14] = '{4'd15, 6'd28, 1'b0, 3, retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1)};
    vecs[15] = '{4'd11, 6'd0,  1'b0, 3, retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0)};
    vecs[16] = '{4'd15, 6'd8,  1'b0, 3, retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0)};

    // Reset state, sampled while reset is still asserted.
    i_reset     = 1'b1;
    i_mem_ready = 1'b1;
    @(posedge i_clk);
    #1;
    e            = '0;
    e.inst_fetch = 1'b1;
    e.ir_write   = 1'b1;
    chk_ctl("reset_ctl", sample(), e);
    chk_int("reset_num_inst", int'(o_num_inst), 0);
    chk_int("reset_halted", int'(o_is_halted), 0);
    do_reset();
    exp_cnt = 16'd0;

    for (int i = 0; i < 17; i++) begin
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].bc, 0, 0, n);
      exp_cnt = exp_cnt + 16'd1;
      chk_int($sformatf("vec%0d_cycles", i), n, vecs[i].cyc);
      chk_ctl($sformatf("vec%0d_retire_ctl", i), log_r[n-1], vecs[i].ctl);
      chk_int($sformatf("vec%0d_num_inst", i), int'(o_num_inst), int'(exp_cnt));
    end

    // R-type SHL: every state's strobes.
    run_instr(4'd15, 6'd6, 1'b0, 0, 0, n);
    exp_cnt = exp_cnt + 16'd1;
    chk_int("shl_cycles", n, 4);
    e = '0; e.inst_fetch = 1'b1; e.ir_write = 1'b1;
    chk_ctl("shl_if", log_r[0], e);
    e = '0; e.alu_b_sel = 2'd2; e.pc_store = 1'b1;
    chk_ctl("shl_id", log_r[1], e);
    e = '0; e.alu_a_sel = 2'd1; e.alu_func = 4'd6;
    chk_ctl("shl_ex", log_r[2], e);
    chk_ctl("shl_wb", log_r[3], retire(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

    // ORI EX uses ORR with the immediate.
    run_instr(4'd5, 6'd0, 1'b0, 0, 0, n);
    exp_cnt = exp_cnt + 16'd1;
    e = '0; e.alu_a_sel = 2'd1; e.alu_b_sel = 2'd1; e.alu_func = 4'd3;
    chk_ctl("ori_ex", log_r[2], e);

    // BEQ taken: branch target computed in BR.
    run_instr(4'd1, 6'd0, 1'b1, 0, 0, n);
    exp_cnt = exp_cnt + 16'd1;
    e = '0; e.alu_a_sel = 2'd2; e.alu_b_sel = 2'd1; e.branch_dst_store = 1'b1;
    chk_ctl("beq_br", log_r[2], e);

    // LWD with two MEM stall cycles.
    run_instr(4'd7, 6'd0, 1'b0, 0, 2, n);
    exp_cnt = exp_cnt + 16'd1;
    chk_int("lwd_stall_cycles", n, 7);
    cnt = 0;
    for (int c = 0; c < n; c++) cnt += int'(log_r[c].mem_read);
    chk_int("lwd_stall_mem_read_cycles", cnt, 3);
    chk_int("lwd_stall_mem_to_reg", int'(log_r[n-1].mem_to_reg), 1);
    chk_int("lwd_stall_num_inst", int'(o_num_inst), int'(exp_cnt));

    // JMP with three IF stall cycles.
    run_instr(4'd9, 6'd0, 1'b0, 3, 0, n);
    exp_cnt = exp_cnt + 16'd1;
    chk_int("jmp_ifstall_cycles", n, 6);
    cnt = 0;
    for (int c = 0; c < n; c++) cnt += int'(log_r[c].ir_write);
    chk_int("jmp_ifstall_ir_write", cnt, 1);
    chk_int("jmp_ifstall_num_inst", int'(o_num_inst), int'(exp_cnt));

    // Counter wrap: preload 0xFFFF, then an undefined opcode retires as a NOP.
    force dut.r_num_inst = 16'hFFFF;
    #1;
    release dut.r_num_inst;
    exp_cnt = 16'hFFFF;
    chk_int("preload_num_inst", int'(o_num_inst), int'(exp_cnt));
    run_instr(4'd11, 6'd0, 1'b0, 0, 0, n);
    exp_cnt = exp_cnt + 16'd1;
    chk_int("wrap_nop_cycles", n, 3);
    chk_int("wrap_num_inst", int'(o_num_inst), 0);
    chk_int("wrap_exp_is_zero", int'(o_num_inst), int'(exp_cnt));

    // Reset in MEM of SWD, coincident with mem_ready: reset must win.
    run_instr(4'd15, 6'd0, 1'b0, 0, 0, n);
    chk_int("pre_swd_num_inst", int'(o_num_inst), 1);
    i_opcode    = 4'd8;
    i_func      = 6'd0;
    i_mem_ready = 1'b1;
    seen        = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (o_mem_write) begin
        seen    = 1'b1;
        i_reset = 1'b1;
        break;
      end
      @(posedge i_clk);
      #1;
    end
    chk_int("swd_reached_mem", int'(seen), 1);
    @(posedge i_clk);
    #1;
    e = '0; e.inst_fetch = 1'b1; e.ir_write = 1'b1;
    chk_ctl("swd_reset_ctl", sample(), e);
    chk_int("swd_reset_num_inst", int'(o_num_inst), 0);
    i_reset = 1'b0;

    // JAL then HLT from reset.
    do_reset();
    run_instr(4'd10, 6'd0, 1'b0, 0, 0, n);
    chk_int("jal_cycles", n, 3);
    chk_int("jal_num_inst", int'(o_num_inst), 1);
    i_opcode    = 4'd15;
    i_func      = 6'd29;
    i_mem_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    e = '0; e.alu_b_sel = 2'd2; e.pc_store = 1'b1;
    chk_ctl("hlt_id_ctl", sample(), e);
    chk_int("hlt_id_not_halted", int'(o_is_halted), 0);
    @(posedge i_clk);
    #1;
    chk_int("hlt_halted", int'(o_is_halted), 1);
    chk_int("hlt_num_inst", int'(o_num_inst), 2);
    for (int c = 0; c < 20; c++) begin
      i_mem_ready = c[0];
      @(negedge i_clk);
      chk_ctl($sformatf("halt_frozen_%0d", c), sample(), '0);
    end
    chk_int("halt_final_num_inst", int'(o_num_inst), 2);
    chk_int("halt_final_halted", int'(o_is_halted), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tsc_multicycle_controller.md
Name: tsc_multicycle_controller

Overview:
- Moore-style state machine that sequences the 16-bit multi-cycle TSC CPU datapath through IF/ID/EX/MEM/WB.
- Decodes the latched instruction's opcode/func and emits per-state control strobes: register write, muxes, ALU op, memory read/write, PC update.
- Owns the retired-instruction counter and the halt flag.
- Sits directly upstream of the datapath and is its only source of control.

Parameters:
- WORD_SIZE, 16, datapath/counter width
- IF_LAT_MAX, 0, reserved; must stay 0 (stalls come only from mem_ready)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  4  instruction[15:12] from the instruction register
- func  in  6  instruction[5:0]
- bcond  in  1  ALU branch-condition result, valid in EX
- mem_ready  in  1  memory completes the current read/write this cycle
- inst_fetch  out  1  IF state: address=PC, read memory
- ir_write  out  1  latch memory data into the instruction register
- mem_read  out  1  data read in MEM
- mem_write  out  1  data write in MEM
- reg_write  out  1  register-file write enable
- reg_dst  out  1  0=rt[9:8], 1=rd[7:6]
- pc_to_reg  out  1  write PC+1 to $2
- mem_to_reg  out  1  write-back data select: loaded data
- alu_a_sel  out  2  0=PC, 1=rs, 2=next_pc
- alu_b_sel  out  2  0=rt, 1=sign-ext imm, 2=const 1
- alu_func  out  4  ALU function code
- branch_type  out  2  0=BNE, 1=BEQ, 2=BGZ, 3=BLZ
- pc_store  out  1  capture ALU output as next_pc
- branch_dst_store  out  1  capture ALU output as branch target
- pc_src  out  2  0=next_pc, 1=branch_dst, 2=jump addr, 3=rs
- pvs_update  out  1  PC write; last cycle of the instruction
- wwd_en  out  1  drive output_port from rs
- num_inst  out  16  retired-instruction count
- is_halted  out  1  HLT executed

Behaviour:
- States (3-bit): IF=0, ID=1, EX=2, MEM=3, WB=4, BR=5, HALT=6.
- Outputs are decoded from state plus opcode/func only, with no combinational path from bcond except to pc_src.
- Any output not listed for a state is 0.
- Reset: state=IF, num_inst=0, is_halted=0. All strobes are 0 except the IF decode (inst_fetch=1).
- Reset wins over every other event in the same cycle. Reset mid-instruction aborts without pvs_update or a count.
- IF:
  - inst_fetch=1.
  - ir_write=1 only when mem_ready=1; then go to ID.
  - Otherwise hold IF (stall, unbounded).
- ID:
  - alu_a_sel=0, alu_b_sel=2, alu_func=ADD, pc_store=1 (next_pc=PC+1).
  - Next state: HLT goes to HALT; Bxx goes to BR; everything else goes to EX.
- BR: alu_a_sel=2, alu_b_sel=1, alu_func=ADD, branch_dst_store=1; go to EX.
- EX, by class:
  - R-ALU (func 0-7): alu_a_sel=1, alu_b_sel=0, alu_func=func[3:0]; go to WB.
  - ADI/ORI/LHI: alu_a_sel=1, alu_b_sel=1, alu_func=ADD/ORR/LHI; go to WB.
  - LWD/SWD: alu_a_sel=1, alu_b_sel=1, alu_func=ADD; go to MEM.
  - Bxx: alu_a_sel=1, alu_b_sel=0, branch_type=opcode[1:0], pc_src=bcond?1:0, pvs_update=1; go to IF.
  - JMP: pc_src=2, pvs_update=1.
  - JAL: additionally reg_write=1, pc_to_reg=1.
  - JPR: pc_src=3, pvs_update=1.
  - JRL: additionally reg_write=1, pc_to_reg=1.
  - WWD: wwd_en=1, pc_src=0, pvs_update=1.
  - Undefined opcode/func: NOP; pc_src=0, pvs_update=1.
  - JMP, JAL, JPR, JRL, WWD and NOP all go to IF.
- MEM: mem_read (LWD) or mem_write (SWD) held until mem_ready=1.
  - SWD completion: pvs_update=1, pc_src=0; go to IF.
  - LWD completion: go to WB.
- WB: reg_write=1, pc_src=0, pvs_update=1; go to IF.
  - reg_dst=1 for R-type.
  - mem_to_reg=1 for LWD.
- HALT: is_halted=1 (registered; set on entry). All strobes are 0; stay until reset. HLT is counted, with pvs_update=0 and the PC held.
- num_inst: +1 on every pvs_update cycle and on entering HALT. Wraps 0xFFFF→0x0000.
- Latency with mem_ready always 1:
  - R/ADI/ORI/LHI/SWD/Bxx: 4 cycles
  - LWD: 5 cycles
  - JMP/JAL/JPR/JRL/WWD/NOP: 3 cycles
  - HLT: 2 cycles to HALT
- Each cycle of mem_ready=0 in IF or MEM adds one cycle.

Decomposition:
- Package tsc_pkg holds:
  - state encodings
  - opcode constants: BNE=0, BEQ=1, BGZ=2, BLZ=3, ADI=4, ORI=5, LHI=6, LWD=7, SWD=8, JMP=9, JAL=10, RTYPE=15
  - func constants: ADD..SHR=0..7, JPR=25, JRL=26, WWD=28, HLT=29
  - ALU codes: ADD=0, SUB=1, AND=2, ORR=3, NOT=4, TCP=5, SHL=6, SHR=7, LHI=8
  - pc_src/alu_sel encodings
- One sub-module is natural: tsc_inst_decoder, combinational, mapping opcode/func to a class enum.

Test Plan:
- ADD (opcode 15, func 0), mem_ready=1 → states IF,ID,EX,WB; reg_write=1 and reg_dst=1 in WB; pvs_update in cycle 4; num_inst 0→1.
- LWD with mem_ready low for 2 cycles in MEM → 7 total cycles; mem_read held 3 cycles; mem_to_reg=1 in WB; no double count.
- BEQ (opcode 1): bcond=1 → pc_src=1 in EX; repeat with bcond=0 → pc_src=0; both 4 cycles with branch_dst_store in BR.
- JAL (opcode 10) → 3 cycles; EX has pc_src=2, reg_write=1, pc_to_reg=1; then HLT (func 29) → is_halted=1 after ID, FSM frozen for 20 cycles, num_inst=2.
- Reset asserted in MEM of SWD → next cycle state=IF, inst_fetch=1, mem_write=0, num_inst=0, no pvs_update.
- Preload num_inst to 0xFFFF via 65535 WWDs (or force) → next retire gives 0x0000; opcode 11 → NOP, 3 cycles, counted.
